ntt_butterfly: RTL and testbench
================================

NTT_BUTTERFLY -- requirements
Module: ntt_butterfly

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-002 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port select_i, input, 1, modulus select: 0 = Dilithium (q=8380417), 1 = Kyber (q=3329); sampled with each accepted operand pair.
REQ-004 SHALL have port valid_i, input, 1, operand pair present.
REQ-005 SHALL have port ready_o, output, 1, block can accept an operand pair this cycle.
REQ-006 SHALL have port a_i, input, 23, butterfly top operand, in range 0..q-1.
REQ-007 SHALL have port wb_i, input, 23, twiddle product w*b mod q from the modular multiplier, in range 0..q-1.
REQ-008 SHALL have port mode_i, input, 1, 0 = forward, 1 = inverse (halving); sampled with each accepted pair.
REQ-009 SHALL have port valid_o, output, 1, result pair present.
REQ-010 SHALL have port ready_i, input, 1, downstream accepts the result pair.
REQ-011 SHALL have port x_o, output, 23, (a + wb) mod q, zero-extended to 23 bits for Kyber.
REQ-012 SHALL have port y_o, output, 23, (a - wb) mod q, zero-extended to 23 bits for Kyber.
REQ-013 SHALL have port clear_i, input, 1, synchronous clear of cnt_o.
REQ-014 SHALL have port cnt_o, output, 8, count of result pairs delivered (valid_o && ready_i).

Function
REQ-015 SHALL transfer an input pair when valid_i && ready_o, and an output pair when valid_o && ready_i.
REQ-016 SHALL be a 2-stage pipeline. Stage 1 registers the raw sum a+wb (24 bits), the difference a-wb+q (24 bits), select and mode. Stage 2 registers the reduced and optionally halved x and y.
REQ-017 SHALL deliver a result exactly 2 cycles after acceptance when ready_i is held high, with one pair per cycle of sustained throughput.
REQ-018 SHALL reduce each value with a single conditional subtraction of q: if value >= q then value - q, else value.
REQ-019 SHALL advance stage 2 when it is empty or ready_i=1, and advance stage 1 when it is empty or stage 2 advances.
REQ-020 SHALL drive ready_o = !v1 || !v2 || ready_i; a combinational path from ready_i to ready_o is permitted.
REQ-021 SHALL hold x_o and y_o stable while valid_o=1 && ready_i=0, and SHALL neither drop nor duplicate pairs under any pattern of valid_i and ready_i.
REQ-022 SHALL carry select per pair, so pairs with different moduli may be interleaved back-to-back.
REQ-023 SHALL increment cnt_o by 1 per delivered pair, wrapping 255 to 0. When clear_i and a delivery occur in the same cycle, clear_i wins and cnt_o becomes 0.
REQ-024 SHALL leave outputs undefined but deadlock-free for operands >= q; the bench does not check them.

Reset
REQ-025 SHALL, on rst_i=1, immediately clear v1, v2 and cnt_o, drive valid_o=0, and drive x_o and y_o to 0.
REQ-026 SHALL discard all in-flight pairs on reset mid-operation, with no output after reset is released until new pairs are accepted.
REQ-027 SHALL drive ready_o=1 while rst_i=1 and in the first cycle after reset is released.

Configuration
REQ-028 SHALL use macro NTT_BUTTERFLY_HALVE_EN to compile the inverse halving feature in or out.
REQ-029 With NTT_BUTTERFLY_HALVE_EN defined, SHALL halve both reduced results in stage 2 when the pair's mode is 1: v even gives v>>1, v odd gives (v+q)>>1.
REQ-030 Without NTT_BUTTERFLY_HALVE_EN, SHALL ignore mode_i, keep no mode storage, and keep latency at 2 cycles.

Verification
REQ-031 Kyber, mode 0, a=3000, wb=1000, ready_i=1 -> 2 cycles later valid_o=1, x_o=671, y_o=2000.
REQ-032 Dilithium, mode 0, a=5, wb=10 -> x_o=15, y_o=8380412; then a=8380416, wb=8380416 -> x_o=8380415, y_o=0.
REQ-033 HALVE_EN, Kyber, mode 1, a=3000, wb=1000 -> x_o=2000, y_o=1000; the same stimulus without the macro -> x_o=671, y_o=2000.
REQ-034 Stream 10 pairs with ready_i toggling every cycle, plus a 5-cycle stall -> all 10 results in order, outputs stable during stall, ready_o=0 only when both stages are full and ready_i=0, cnt_o=10.
REQ-035 Assert rst_i asynchronously with 2 pairs in flight -> valid_o=0 and cnt_o=0 at once; no stale result after release; 256 deliveries -> cnt_o=0; clear_i on a delivery cycle -> cnt_o=0.

Source files
------------

// File: rtl/ntt_butterfly.sv
// ntt_butterfly: two-stage pipelined NTT butterfly add/sub with selectable Kyber/Dilithium modulus
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   select_i              modulus per pair: 0 = Dilithium (8380417), 1 = Kyber (3329)
//   valid_i/ready_o       operand handshake for a_i and wb_i (wb_i = w*b mod q)
//   mode_i                0 = forward, 1 = inverse halving (NTT_BUTTERFLY_HALVE_EN only)
//   valid_o/ready_i       result handshake for x_o = (a+wb) mod q and y_o = (a-wb) mod q
//   clear_i, cnt_o        synchronous clear and 8-bit count of delivered result pairs
// Define NTT_BUTTERFLY_HALVE_EN to compile in the inverse halving step.
module ntt_butterfly (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        select_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [22:0] a_i,
  input  logic [22:0] wb_i,
  input  logic        mode_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [22:0] x_o,
  output logic [22:0] y_o,
  input  logic        clear_i,
  output logic [7:0]  cnt_o
);
  localparam logic [23:0] Q_DIL = 24'd8380417;
  localparam logic [23:0] Q_KYB = 24'd3329;
  logic        v1, v2, s1_sel, adv1, adv2;
  logic [23:0] s1_sum, s1_dif, q_in, q1;
  logic [22:0] sum_r, dif_r, x_n, y_n;
  assign adv2    = !v2 || ready_i;
  assign adv1    = !v1 || adv2;
  assign ready_o = adv1;
  assign valid_o = v2;
  assign q_in    = select_i ? Q_KYB : Q_DIL;
  assign q1      = s1_sel ? Q_KYB : Q_DIL;
  // Both raw values are below 2q, so one conditional subtraction fully reduces them.
  assign sum_r   = 23'(s1_sum >= q1 ? s1_sum - q1 : s1_sum);
  assign dif_r   = 23'(s1_dif >= q1 ? s1_dif - q1 : s1_dif);
`ifdef NTT_BUTTERFLY_HALVE_EN
  logic s1_mode;
  // Halving mod q: odd values get q added first so the shift is exact.
  assign x_n = s1_mode ? 23'(({1'b0, sum_r} + (sum_r[0] ? q1 : 24'd0)) >> 1) : sum_r;
  assign y_n = s1_mode ? 23'(({1'b0, dif_r} + (dif_r[0] ? q1 : 24'd0)) >> 1) : dif_r;
`else
  logic unused_mode;
  assign unused_mode = mode_i;
  assign x_n = sum_r;
  assign y_n = dif_r;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      s1_sel <= 1'b0;
      s1_sum <= '0;
      s1_dif <= '0;
`ifdef NTT_BUTTERFLY_HALVE_EN
      s1_mode <= 1'b0;
`endif
      x_o    <= '0;
      y_o    <= '0;
      cnt_o  <= '0;
    end else begin
      if (adv1) v1 <= valid_i;
      if (adv1 && valid_i) begin
        s1_sel <= select_i;
        s1_sum <= {1'b0, a_i} + {1'b0, wb_i};
        // Adding q keeps the difference non-negative in 24 bits.
        s1_dif <= {1'b0, a_i} - {1'b0, wb_i} + q_in;
`ifdef NTT_BUTTERFLY_HALVE_EN
        s1_mode <= mode_i;
`endif
      end
      if (adv2) v2 <= v1;
      if (adv2 && v1) begin
        x_o <= x_n;
        y_o <= y_n;
      end
      if (clear_i) cnt_o <= '0;
      else if (v2 && ready_i) cnt_o <= cnt_o + 8'd1;
    end
endmodule

// File: tb/tb_ntt_butterfly.sv
// tb_ntt_butterfly: directed self-checking bench for ntt_butterfly
module tb_ntt_butterfly;
  logic        clk_i = 0, rst_i = 1, select_i = 0, valid_i = 0, ready_o, mode_i = 0;
  logic        valid_o, ready_i = 1, clear_i = 0;
  logic [22:0] a_i = 0, wb_i = 0, x_o, y_o;
  logic [7:0]  cnt_o;
  int n_cmp = 0, n_err = 0;
  ntt_butterfly dut (
    .clk_i(clk_i), .rst_i(rst_i), .select_i(select_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .wb_i(wb_i), .mode_i(mode_i), .valid_o(valid_o), .ready_i(ready_i),
    .x_o(x_o), .y_o(y_o), .clear_i(clear_i), .cnt_o(cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic sel, input logic md, input int a, input int b);
    valid_i = 1; select_i = sel; mode_i = md; a_i = 23'(a); wb_i = 23'(b);
  endtask
  task automatic step();
    @(negedge clk_i);
  endtask
  int sa[10], sb[10], ex[10], ey[10];
  logic ss[10];
  initial begin
    #2;
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_x", x_o, 0);
    check("rst_cnt", cnt_o, 0);
    step(); step();
    rst_i = 0;
    #1 check("ready_after_rst", ready_o, 1);
    step();
    drive(1, 0, 3000, 1000);
    step(); valid_i = 0;
    check("kyb_lat1", valid_o, 0);
    step();
    check("kyb_valid", valid_o, 1);
    check("kyb_x", x_o, 671);
    check("kyb_y", y_o, 2000);
    step();
    check("kyb_cnt", cnt_o, 1);
    check("kyb_done", valid_o, 0);
    drive(0, 0, 5, 10);
    step(); drive(0, 0, 8380416, 8380416);
    step(); valid_i = 0;
    check("dil1_x", x_o, 15);
    check("dil1_y", y_o, 8380412);
    step();
    check("dil2_valid", valid_o, 1);
    check("dil2_x", x_o, 8380415);
    check("dil2_y", y_o, 0);
    drive(1, 1, 3000, 1000);
    step(); valid_i = 0;
    step();
`ifdef NTT_BUTTERFLY_HALVE_EN
    check("halve_x", x_o, 2000);
    check("halve_y", y_o, 1000);
`else
    check("nohalve_x", x_o, 671);
    check("nohalve_y", y_o, 2000);
`endif
    step();
    check("cnt4", cnt_o, 4);
    clear_i = 1;
    step(); clear_i = 0;
    check("clear", cnt_o, 0);
    for (int i = 0; i < 10; i++) begin
      int q;
      ss[i] = (i % 3 != 0);
      q = ss[i] ? 3329 : 8380417;
      sa[i] = (i * 1234 + 7) % q;
      sb[i] = (i * 977 + 3) % q;
      ex[i] = (sa[i] + sb[i]) % q;
      ey[i] = (sa[i] + q - sb[i]) % q;
    end
    begin
      int tx = 0, rx = 0, cyc = 0;
      logic hold = 0;
      logic [22:0] px = 0, py = 0;
      while (rx < 10 && cyc < 200) begin
        ready_i = (cyc >= 4 && cyc < 9) ? 1'b0 : 1'(cyc % 2);
        if (tx < 10) drive(ss[tx], 0, sa[tx], sb[tx]); else valid_i = 0;
        #4;
        check("str_ready", ready_o, !((tx - rx) == 2 && !ready_i));
        if (hold) begin
          check("str_hold_v", valid_o, 1);
          check("str_hold_x", x_o, px);
          check("str_hold_y", y_o, py);
        end
        hold = valid_o && !ready_i;
        px = x_o; py = y_o;
        if (valid_o && ready_i) begin
          check("str_x", x_o, ex[rx]);
          check("str_y", y_o, ey[rx]);
          rx++;
        end
        if (valid_i && ready_o) tx++;
        cyc++;
        step();
      end
      check("str_count", rx, 10);
    end
    valid_i = 0; ready_i = 1;
    check("str_cnt", cnt_o, 10);
    clear_i = 1;
    step(); clear_i = 0;
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, i % 3329, 7);
      step();
    end
    valid_i = 0;
    step();
    check("cnt255", cnt_o, 255);
    step();
    check("cnt_wrap", cnt_o, 0);
    drive(1, 0, 1, 2);
    step(); valid_i = 0;
    step(); step();
    check("cnt1", cnt_o, 1);
    drive(1, 0, 3, 4);
    step(); valid_i = 0;
    step();
    check("clr_del_v", valid_o, 1);
    clear_i = 1;
    step(); clear_i = 0;
    check("clr_del_cnt", cnt_o, 0);
    check("clr_del_gone", valid_o, 0);
    drive(1, 0, 10, 20);
    step(); valid_i = 0;
    step(); step();
    check("pre_rst_cnt", cnt_o, 1);
    ready_i = 0;
    drive(1, 0, 100, 50);
    step(); drive(0, 0, 200, 60);
    step(); valid_i = 0;
    check("inflight_v", valid_o, 1);
    check("inflight_full", ready_o, 0);
    #2 rst_i = 1;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_cnt", cnt_o, 0);
    check("arst_x", x_o, 0);
    check("arst_ready", ready_o, 1);
    step();
    rst_i = 0; ready_i = 1;
    #1 check("rel_ready", ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_stale", valid_o, 0);
    end
    check("post_rst_cnt", cnt_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
